pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
- Parametrised multi-channel successor to the single-channel button-controlled PWM.
- NUM_CH channels share one period counter.
- Each channel has its own duty register, adjusted by debounced increase/decrease buttons applied to the currently selected channel; a third button cycles the selection.
- Duty updates are shadowed and committed at period start (glitch-free). Supports edge-aligned and center-aligned modes.

Parameters:
- NUM_CH, 4, number of PWM channels (1..16)
- PERIOD, 10, counter steps per PWM period (2..65535)
- DUTY_STEP, 1, duty change per accepted button press
- INIT_DUTY, 5, reset duty of every channel (0..PERIOD)
- DEBOUNCE_CYCLES, 20, consecutive stable samples needed to accept a button level
- CNT_W, $clog2(PERIOD+1), counter/duty width (derived, do not override)
- CH_W, max(1,$clog2(NUM_CH)), channel-select width (derived)

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_increase_duty  in  1  async button: raise selected channel duty
- i_decrease_duty  in  1  async button: lower selected channel duty
- i_next_channel  in  1  async button: advance channel selection
- i_center_mode  in  1  0 = edge-aligned, 1 = center-aligned (quasi-static)
- o_pwm  out  NUM_CH  registered PWM outputs
- o_channel_sel  out  CH_W  currently selected channel
- o_period_start  out  1  one-cycle pulse on the first cycle of each period

Behaviour:
- Reset (async assert, sync-release use): counter=0, direction=up, all active and shadow duties=INIT_DUTY, o_channel_sel=0, o_pwm=0, o_period_start=0, debouncers' stable level=0, counters cleared.
- Button path per input: 2-flop synchronizer -> debouncer. Debounced level changes only after DEBOUNCE_CYCLES consecutive cycles with the synchronized input differing from the current level; any mismatch-free sample resets the count. A 0->1 debounced transition produces a one-cycle press pulse. Press latency: 2 + DEBOUNCE_CYCLES + 1 cycles from a clean input edge.
- Shadow duty update (same cycle as the press pulse, targeting the channel selected before any select change in that cycle):
  - inc only: shadow = min(shadow + DUTY_STEP, PERIOD); saturate, no wrap.
  - dec only: shadow = (shadow < DUTY_STEP) ? 0 : shadow - DUTY_STEP.
  - inc and dec in the same cycle: both ignored.
  - next_channel: sel = (sel == NUM_CH-1) ? 0 : sel+1; applied together with a duty update to the old channel if both pulse in the same cycle.
- Arithmetic is done at CNT_W+1 bits to avoid overflow before saturation.
- Edge-aligned (mode 0): counter 0..PERIOD-1, wrap to 0. Period = PERIOD cycles.
- Center-aligned (mode 1): counter up 0..PERIOD-1, then down PERIOD-1..0; each endpoint is held for two cycles. Period = 2*PERIOD cycles.
- Period start = counter==0 with direction up (first cycle after reset counts). At that cycle:
  - all active duties <= shadow duties;
  - mode is latched;
  - o_period_start pulses.
  - Mode changes mid-period take effect only at the next period start.
- Output: o_pwm[k] registered = (counter < active_duty[k]); one-cycle latency from counter.
  - duty 0 -> constant 0; duty PERIOD -> constant 1.
  - In mode 1, high time = 2*duty cycles, centred in the period.
- Reset mid-period: outputs drop to 0 immediately (async); pending shadow changes are discarded.

Decomposition:
- Shared package pwm_pkg: mode encoding constants (PWM_EDGE=1'b0, PWM_CENTER=1'b1) and a default DEBOUNCE_CYCLES constant shared with the other button-driven blocks.
- One sub-module: pwm_debounce (synchronizer + stable counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.

Test Plan:
- Reset with NUM_CH=2, PERIOD=10, DEBOUNCE_CYCLES=4 -> o_pwm=0 in reset; after release each channel is high 5 of every 10 cycles; o_period_start pulses every 10 cycles.
- Clean inc press on ch0 -> ch0 shadow=6 after 7 cycles; active duty changes only at the next o_period_start; ch0 high 6/10, ch1 unchanged at 5/10.
- Bouncy inc (toggles every 2 cycles for 20 cycles, then stable high) -> exactly one increment. Six more presses -> ch0 saturates at 10 (constant 1); dec from 0 stays at 0 (constant 0).
- next_channel press -> o_channel_sel 0->1; with NUM_CH=2 a second press wraps to 0. Inc and next_channel in the same cycle -> ch0 incremented, selection moves to 1.
- Inc and dec pulsing in the same cycle -> no duty change on any channel.
- i_center_mode=1 raised mid-period -> current period stays edge-aligned; next period is 20 cycles; duty 3 yields 6 high cycles centred in the period; assert i_rst_n low mid-period -> o_pwm=0 immediately, duties back to 5.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM mode encodings, counter direction type and button debounce default
package pwm_pkg;
  localparam logic PWM_EDGE = 1'b0;
  localparam logic PWM_CENTER = 1'b1;
  localparam int DEBOUNCE_DEFAULT = 20;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
endpackage

// File: rtl/pwm_multi_if.sv
// pwm_multi_if: button/mode inputs and PWM outputs of the multi-channel PWM
interface pwm_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic i_increase_duty;
  logic i_decrease_duty;
  logic i_next_channel;
  logic i_center_mode;
  logic [NUM_CH-1:0] o_pwm;
  logic [CH_W-1:0] o_channel_sel;
  logic o_period_start;
  modport master (
    output i_increase_duty, i_decrease_duty, i_next_channel, i_center_mode,
    input o_pwm, o_channel_sel, o_period_start
  );
  modport slave (
    input i_increase_duty, i_decrease_duty, i_next_channel, i_center_mode,
    output o_pwm, o_channel_sel, o_period_start
  );
endinterface

// File: rtl/pwm_debounce.sv
// pwm_debounce: 2-flop synchronizer, stable-level debouncer and one-cycle press pulse
module pwm_debounce
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic level, level_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync <= '0;
      level <= 1'b0;
      level_q <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[0], btn};
      level_q <= level;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign press = level & ~level_q;
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: NUM_CH PWM channels on one shared period counter, with button-adjusted
// shadow duties committed at period start; edge- or center-aligned.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PERIOD = 10,
  parameter int DUTY_STEP = 1,
  parameter int INIT_DUTY = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  localparam int CNT_W = $clog2(PERIOD + 1),
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic i_clk,
  input logic i_rst_n,
  pwm_multi_if.slave bus
);
  localparam logic [CNT_W:0] PER_X = (CNT_W + 1)'(PERIOD);
  localparam logic [CNT_W:0] STEP_X = (CNT_W + 1)'(DUTY_STEP);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic [CH_W-1:0] SEL_LAST = CH_W'(NUM_CH - 1);
  dir_e dir, dir_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic mode_q;
  logic [CH_W-1:0] sel;
  logic [CNT_W-1:0] shadow [NUM_CH];
  logic [CNT_W-1:0] active [NUM_CH];
  logic inc, dec, nxt, start;
  logic [CNT_W:0] cur, up_v, dn_v, duty_nx;
  pwm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .btn(bus.i_increase_duty), .press(inc)
  );
  pwm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .btn(bus.i_decrease_duty), .press(dec)
  );
  pwm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nxt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .btn(bus.i_next_channel), .press(nxt)
  );
  assign start = (cnt == '0) && (dir == DIR_UP);
  assign bus.o_channel_sel = sel;
  // In center mode both endpoints repeat once as the direction turns around.
  always_comb begin
    cnt_nx = cnt + 1'b1;
    dir_nx = dir;
    if (dir == DIR_UP && cnt == LAST) begin
      cnt_nx = (mode_q == PWM_CENTER) ? cnt : '0;
      dir_nx = (mode_q == PWM_CENTER) ? DIR_DOWN : DIR_UP;
    end else if (dir == DIR_DOWN) begin
      cnt_nx = (cnt == '0) ? cnt : cnt - 1'b1;
      dir_nx = (cnt == '0) ? DIR_UP : DIR_DOWN;
    end
  end
  always_comb begin
    cur = {1'b0, shadow[sel]};
    up_v = (cur + STEP_X > PER_X) ? PER_X : cur + STEP_X;
    dn_v = (cur < STEP_X) ? '0 : cur - STEP_X;
    duty_nx = (inc && !dec) ? up_v : (dec && !inc) ? dn_v : cur;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dir <= DIR_UP;
      cnt <= '0;
    end else begin
      dir <= dir_nx;
      cnt <= cnt_nx;
    end
  end
  // The first cycle of a period compares against the duty being committed right now.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q <= PWM_EDGE;
      sel <= '0;
      bus.o_pwm <= '0;
      bus.o_period_start <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow[k] <= CNT_W'(INIT_DUTY);
        active[k] <= CNT_W'(INIT_DUTY);
      end
    end else begin
      bus.o_period_start <= start;
      if (start) mode_q <= bus.i_center_mode;
      if (nxt) sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (start) active[k] <= shadow[k];
        if (CH_W'(k) == sel) shadow[k] <= duty_nx[CNT_W-1:0];
        bus.o_pwm[k] <= cnt < (start ? shadow[k] : active[k]);
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: randomized button presses checked cycle-by-cycle against a period-level PWM model
module tb_pwm_multi;
  localparam int NUM_CH = 2;
  localparam int PERIOD = 10;
  localparam int STEP = 1;
  localparam int INIT = 5;
  localparam int DEB = 4;
  localparam int CH_W = 1;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int duty [NUM_CH];
  int sel = 0;
  bit mode = 1'b0;
  int hi0 = 0;
  always #5 i_clk = ~i_clk;
  pwm_multi_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();
  pwm_multi #(
    .NUM_CH(NUM_CH), .PERIOD(PERIOD), .DUTY_STEP(STEP), .INIT_DUTY(INIT), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge i_clk);
  endtask
  task automatic reset_model();
    for (int k = 0; k < NUM_CH; k++) duty[k] = INIT;
    sel = 0;
  endtask
  task automatic set_btns(bit a, bit b, bit c);
    bus.i_increase_duty = a;
    bus.i_decrease_duty = b;
    bus.i_next_channel = c;
  endtask
  task automatic apply(bit inc, bit dec, bit nxt);
    if (inc && !dec) duty[sel] = (duty[sel] + STEP > PERIOD) ? PERIOD : duty[sel] + STEP;
    else if (dec && !inc) duty[sel] = (duty[sel] < STEP) ? 0 : duty[sel] - STEP;
    if (nxt) sel = (sel + 1) % NUM_CH;
  endtask
  task automatic press(bit inc, bit dec, bit nxt);
    set_btns(inc, dec, nxt);
    cyc(3 * DEB);
    set_btns(0, 0, 0);
    cyc(3 * DEB);
    apply(inc, dec, nxt);
    check("sel", 32'(bus.o_channel_sel), sel);
  endtask
  task automatic wait_start(output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!bus.o_period_start && n < 200);
    if (n >= 200) check("start_timeout", 0, 1);
  endtask
  task automatic measure_from_here();
    int len, c;
    logic [NUM_CH-1:0] exp;
    len = mode ? 2 * PERIOD : PERIOD;
    hi0 = 0;
    for (int t = 0; t < len; t++) begin
      c = (mode && t >= PERIOD) ? 2 * PERIOD - 1 - t : t;
      for (int k = 0; k < NUM_CH; k++) exp[k] = c < duty[k];
      check($sformatf("pwm t%0d", t), 32'(bus.o_pwm), 32'(exp));
      check($sformatf("start t%0d", t), 32'(bus.o_period_start), 32'(t == 0));
      hi0 += int'(bus.o_pwm[0]);
      cyc(1);
    end
    check("next_start", 32'(bus.o_period_start), 1);
  endtask
  task automatic measure_period();
    int n;
    wait_start(n);
    measure_from_here();
  endtask
  initial begin
    int n, op;
    set_btns(0, 0, 0);
    bus.i_center_mode = 1'b0;
    reset_model();
    cyc(3);
    check("rst_pwm", 32'(bus.o_pwm), 0);
    check("rst_sel", 32'(bus.o_channel_sel), 0);
    check("rst_start", 32'(bus.o_period_start), 0);
    i_rst_n = 1'b1;
    measure_period();
    measure_period();
    press(1, 0, 0);
    measure_period();
    for (int i = 0; i < 10; i++) begin
      bus.i_increase_duty = ~bus.i_increase_duty;
      cyc(2);
    end
    bus.i_increase_duty = 1'b1;
    cyc(3 * DEB);
    bus.i_increase_duty = 1'b0;
    cyc(3 * DEB);
    apply(1, 0, 0);
    measure_period();
    repeat (6) press(1, 0, 0);
    measure_period();
    repeat (11) press(0, 1, 0);
    measure_period();
    press(0, 0, 1);
    press(0, 0, 1);
    press(1, 0, 1);
    measure_period();
    press(1, 1, 0);
    measure_period();
    repeat (10) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0: press(1, 0, 0);
        1: press(0, 1, 0);
        2: press(0, 0, 1);
        3: press(1, 0, 1);
        4: press(1, 1, 0);
        default: press(0, 1, 1);
      endcase
      measure_period();
    end
    i_rst_n = 1'b0;
    cyc(2);
    i_rst_n = 1'b1;
    reset_model();
    press(0, 1, 0);
    press(0, 1, 0);
    wait_start(n);
    cyc(3);
    bus.i_center_mode = 1'b1;
    wait_start(n);
    check("edge_len_kept", n, PERIOD - 3);
    mode = 1'b1;
    measure_from_here();
    check("center_high", hi0, 2 * duty[0]);
    cyc(1);
    check("pre_rst_pwm", 32'(bus.o_pwm), 3);
    #1 i_rst_n = 1'b0;
    #1 check("async_rst_pwm", 32'(bus.o_pwm), 0);
    check("async_rst_sel", 32'(bus.o_channel_sel), 0);
    cyc(2);
    i_rst_n = 1'b1;
    reset_model();
    measure_period();
    check("rst_duty_high", hi0, 2 * INIT);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
